// File: rtl/param_chunk_adder.sv
`default_nettype none
// ============================================================================
//  Module      : param_chunk_adder
//  Description : Combinational W-bit ripple-carry adder. It is the per-cycle
//                slice of the serial adder datapath.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_chunk_adder #(
    parameter int W = 1
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic [W:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_ripple
        assign s[i]       = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[W];

endmodule
`default_nettype wire

// File: rtl/param_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : param_serial_adder
//  Description : Multi-cycle adder computing {cout,s} = a + b + cin, CHUNK
//                bits per clock, with a start/busy/done handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
module param_serial_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             cout
);

    function automatic int clog2_min1(input int v);
        int r;
        r = 0;
        for (int p = 1; p < v; p = p * 2) r++;
        return (r < 1) ? 1 : r;
    endfunction

    // Guarded so a bad CHUNK does not turn into a divide-by-zero before the check fires.
    localparam int c_N  = (CHUNK >= 1) ? (WIDTH / CHUNK) : 1;
    localparam int c_CW = clog2_min1(c_N);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(c_N - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    if ((CHUNK < 1) || ((WIDTH % CHUNK) != 0) || (WIDTH < 1)) begin : g_bad_params
        $error("param_serial_adder: CHUNK must be >= 1 and divide WIDTH exactly");
    end

    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_carry;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_next;
    logic [CHUNK-1:0] w_chunk_s;
    logic             w_chunk_cout;
    logic             w_load;
    logic             w_last;

    param_chunk_adder #(
        .W (CHUNK)
    ) u_chunk_adder (
        .a    (r_a[CHUNK-1:0]),
        .b    (r_b[CHUNK-1:0]),
        .cin  (r_carry),
        .s    (w_chunk_s),
        .cout (w_chunk_cout)
    );

    // New sum chunk enters at the MSB end; after N shifts chunk 0 sits at the LSBs.
    assign w_acc_next = WIDTH'({w_chunk_s, r_acc} >> CHUNK);

    assign w_load = start && ((r_state == c_IDLE) || (r_state == c_DONE));
    assign w_last = (r_state == c_RUN) && (r_cnt == c_LAST);

    assign busy = (r_state == c_RUN);
    assign done = (r_state == c_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_next = c_RUN;
            c_RUN:   if (w_last) w_state_next = c_DONE;
            c_DONE:  w_state_next = start ? c_RUN : c_IDLE;
            default: w_state_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_acc   <= '0;
            s       <= '0;
            cout    <= 1'b0;
        end else if (w_load) begin
            r_cnt   <= '0;
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_acc   <= '0;
        end else if (r_state == c_RUN) begin
            r_cnt   <= r_cnt + 1'b1;
            r_a     <= r_a >> CHUNK;
            r_b     <= r_b >> CHUNK;
            r_carry <= w_chunk_cout;
            r_acc   <= w_acc_next;
            if (w_last) begin
                s    <= w_acc_next;
                cout <= w_chunk_cout;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_param_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_param_serial_adder
//  Description : Self-checking bench; instance 0 is WIDTH=8/CHUNK=1 and
//                instance 1 is WIDTH=8/CHUNK=4, sharing clock and reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_param_serial_adder;

    logic       clk;
    logic       rst;
    logic       start  [2];
    logic [7:0] a      [2];
    logic [7:0] b      [2];
    logic       cin    [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic [7:0] s_o    [2];
    logic       cout_o [2];

    int n_checks = 0;
    int n_fail   = 0;
    int c_n [2]  = '{8, 2};

    param_serial_adder #(.WIDTH(8), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start[0]), .a(a[0]), .b(b[0]), .cin(cin[0]),
        .busy(busy_o[0]), .done(done_o[0]), .s(s_o[0]), .cout(cout_o[0])
    );

    param_serial_adder #(.WIDTH(8), .CHUNK(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start[1]), .a(a[1]), .b(b[1]), .cin(cin[1]),
        .busy(busy_o[1]), .done(done_o[1]), .s(s_o[1]), .cout(cout_o[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] av;
        logic [7:0] bv;
        logic       ci;
        logic [7:0] es;
        logic       ec;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Leaves the bench at the negedge of the done cycle (or after the cycle budget).
    task automatic wait_done(input int k, output int nbusy, output logic got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            if (done_o[k] === 1'b1) got = 1'b1;
            else begin
                if (busy_o[k] === 1'b1) nbusy++;
                @(negedge clk);
            end
        end
    endtask

    task automatic run_add(input int k, input logic [7:0] av, input logic [7:0] bv,
                           input logic ci, output int nbusy, output logic got);
        @(negedge clk);
        start[k] = 1'b1; a[k] = av; b[k] = bv; cin[k] = ci;
        @(negedge clk);
        start[k] = 1'b0;
        wait_done(k, nbusy, got);
    endtask

    vec_t       vecs [8];
    logic [7:0] last_s [2];
    int         nb;
    logic       got;
    logic       saw_done;

    initial begin
        vecs[0] = '{0, 8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{1, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[4] = '{0, 8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{1, 8'h80, 8'h7F, 1'b1, 8'h00, 1'b1};
        vecs[6] = '{1, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
        vecs[7] = '{0, 8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

        for (int k = 0; k < 2; k++) begin
            start[k] = 1'b0; a[k] = '0; b[k] = '0; cin[k] = 1'b0;
        end

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("reset busy[%0d]", k), 32'(busy_o[k]), 0);
            check($sformatf("reset done[%0d]", k), 32'(done_o[k]), 0);
            check($sformatf("reset s[%0d]", k),    32'(s_o[k]),    0);
            check($sformatf("reset cout[%0d]", k), 32'(cout_o[k]), 0);
        end
        rst = 1'b0;

        // Table-driven adds
        for (int i = 0; i < 8; i++) begin
            run_add(vecs[i].k, vecs[i].av, vecs[i].bv, vecs[i].ci, nb, got);
            check($sformatf("vec%0d done", i),   32'(got), 1);
            check($sformatf("vec%0d busy cycles", i), 32'(nb), 32'(c_n[vecs[i].k]));
            check($sformatf("vec%0d s", i),      32'(s_o[vecs[i].k]),    32'(vecs[i].es));
            check($sformatf("vec%0d cout", i),   32'(cout_o[vecs[i].k]), 32'(vecs[i].ec));
            last_s[vecs[i].k] = vecs[i].es;
        end

        // Operands and start changing mid-run must not disturb the add in flight
        @(negedge clk);
        start[0] = 1'b1; a[0] = 8'h10; b[0] = 8'h20; cin[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        check("hold s prev early", 32'(s_o[0]), 32'(last_s[0]));
        repeat (2) @(negedge clk);
        a[0] = 8'hAA; b[0] = 8'h55; cin[0] = 1'b1; start[0] = 1'b1;
        @(negedge clk);
        start[0] = 1'b0;
        check("hold busy", 32'(busy_o[0]), 1);
        check("hold s prev mid", 32'(s_o[0]), 32'(last_s[0]));
        wait_done(0, nb, got);
        check("hold done", 32'(got), 1);
        check("hold s", 32'(s_o[0]), 32'h30);
        check("hold cout", 32'(cout_o[0]), 0);
        @(negedge clk);
        check("hold back to idle", 32'(busy_o[0]), 0);

        // Back-to-back on the CHUNK=4 instance
        run_add(1, 8'h05, 8'h06, 1'b0, nb, got);
        check("b2b first done", 32'(got), 1);
        check("b2b first s", 32'(s_o[1]), 32'h0B);
        start[1] = 1'b1; a[1] = 8'h01; b[1] = 8'h02; cin[1] = 1'b0;
        @(negedge clk);
        start[1] = 1'b0;
        check("b2b no idle bubble", 32'(busy_o[1]), 1);
        check("b2b s prev", 32'(s_o[1]), 32'h0B);
        wait_done(1, nb, got);
        check("b2b second done", 32'(got), 1);
        check("b2b second busy cycles", 32'(nb), 2);
        check("b2b second s", 32'(s_o[1]), 32'h03);
        check("b2b second cout", 32'(cout_o[1]), 0);

        // Reset in RUN cycle 3 of a CHUNK=1 add; clears asynchronously
        @(negedge clk);
        start[0] = 1'b1; a[0] = 8'h5A; b[0] = 8'h3C; cin[0] = 1'b0;
        @(negedge clk);
        start[0] = 1'b0;
        repeat (2) @(negedge clk);
        check("abort pre busy", 32'(busy_o[0]), 1);
        rst = 1'b1;
        #1;
        check("abort async s", 32'(s_o[0]), 0);
        check("abort async cout", 32'(cout_o[0]), 0);
        check("abort async busy", 32'(busy_o[0]), 0);
        @(negedge clk);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done_o[0] === 1'b1) saw_done = 1'b1;
            @(negedge clk);
        end
        check("abort no done pulse", 32'(saw_done), 0);
        run_add(0, 8'h80, 8'h80, 1'b0, nb, got);
        check("after abort done", 32'(got), 1);
        check("after abort s", 32'(s_o[0]), 32'h00);
        check("after abort cout", 32'(cout_o[0]), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
